uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_fifo_if.sv | 14 +
 rtl/rx_fifo.sv | 51 +++++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Push/pop bundle between the receiver FSM (master) and its buffer (slave).
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rx_empty;
    logic                  rx_full;

    modport master (output push, push_data, rd_req, input rd_data, rx_empty, rx_full);
    modport slave  (input push, push_data, rd_req, output rd_data, rx_empty, rx_full);
endinterface

// File: rtl/rx_fifo.sv
// First-word fall-through receive buffer; a push into a full buffer is
// accepted only when a pop frees a slot in the same cycle.
module rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           pCLK,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  do_push, do_pop;

    // NOTE: every always_comb output is assigned unconditionally up front, so no path can infer a latch.
    always_comb begin
        do_pop   = bus.rd_req && (count_q != '0);
        do_push  = bus.push && ((count_q != FULL_COUNT) || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge pCLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag masks stale entries on rd_data.
    always_ff @(posedge pCLK) begin
        if (do_push) begin
            mem[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.rd_data  = (count_q == '0) ? '0 : mem[rd_ptr_q];
    assign bus.rx_empty = (count_q == '0);
    assign bus.rx_full  = (count_q == FULL_COUNT);
endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling 8N1-style UART receiver feeding a small receive FIFO,
// with sticky frame-error and overrun flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  pCLK,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rx_en,
    input  logic [15:0]           limit,
    input  logic                  rd_req,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  frame_err,
    output logic                  overrun
);
    localparam int N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_rx_state_t        state_q, state_d;
    logic                  rx_meta_q, rx_sync_q;
    logic [15:0]           presc_q, presc_d;
    logic [3:0]            s_cnt_q, s_cnt_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  tick, push, frame_set;

    uart_rx_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) fifo_bus ();

    always_comb begin
        tick      = (limit != 16'd0) && (presc_q == limit - 16'd1);
        presc_d   = tick ? '0 : presc_q + 16'd1;
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;

        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Realign the prescaler to the falling edge of the start bit.
                    if (!rx_sync_q) begin
                        presc_d = '0;
                        s_cnt_d = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt_q == 4'(MID_SAMPLE)) begin
                            if (!rx_sync_q) begin
                                state_d = DATA;
                                s_cnt_d = '0;
                                n_d     = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            s_cnt_d = s_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                        if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
                            shreg_d = {rx_sync_q, shreg_q[DATA_WIDTH-1:1]};
                            if (n_q == N_W'(DATA_WIDTH - 1)) begin
                                state_d = STOP;
                            end else begin
                                n_d = n_q + 1'b1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                        if (s_cnt_q == 4'(OVERSAMPLE - 1)) begin
                            push      = rx_sync_q;
                            frame_set = !rx_sync_q;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Set wins over clear when both land in the same cycle.
        frame_err_d = frame_set | (frame_err_q & ~err_clr);
        overrun_d   = (push & fifo_bus.rx_full & ~rd_req) | (overrun_q & ~err_clr);
    end

    always_ff @(posedge pCLK) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= IDLE;
            presc_q     <= '0;
            s_cnt_q     <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            presc_q     <= presc_d;
            s_cnt_q     <= s_cnt_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign fifo_bus.push      = push;
    assign fifo_bus.push_data = shreg_d;
    assign fifo_bus.rd_req    = rd_req;

    rx_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .pCLK  (pCLK),
        .reset (reset),
        .bus   (fifo_bus.slave)
    );

    assign rd_data   = fifo_bus.rd_data;
    assign rx_empty  = fifo_bus.rx_empty;
    assign rx_full   = fifo_bus.rx_full;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a serial driver plus a queue-based model of the
// receive buffer and sticky flags; a monitor checks every pop it sees.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic        pCLK = 1'b0;
    logic        reset;
    logic        rx;
    logic        rx_en;
    logic        err_clr;
    logic [15:0] limit;
    logic        frame_err;
    logic        overrun;

    uart_rx_fifo_if #(.DATA_WIDTH(W)) bus ();

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q[$];
    logic       exp_frame_err = 1'b0;
    logic       exp_overrun   = 1'b0;

    always #5 pCLK = ~pCLK;

    uart_rx_fifo #(
        .DATA_WIDTH(W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .pCLK      (pCLK),
        .reset     (reset),
        .rx        (rx),
        .rx_en     (rx_en),
        .limit     (limit),
        .rd_req    (bus.rd_req),
        .err_clr   (err_clr),
        .rd_data   (bus.rd_data),
        .rx_empty  (bus.rx_empty),
        .rx_full   (bus.rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest byte the model holds.
    initial begin
        forever begin
            @(negedge pCLK);
            #2;
            if (bus.rd_req === 1'b1) begin
                if (model_q.size() == 0) begin
                    check("pop_when_empty_ignored", bus.rx_empty, 1);
                end else begin
                    check("rx_empty_at_pop", bus.rx_empty, 0);
                    check("rd_data", bus.rd_data, model_q.pop_front());
                end
            end
        end
    end

    // Serial driver with 16*limit clocks per bit; the model records the outcome
    // the frame's rules demand once the stop bit has been sent.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit timing_chk, input bit pop_mid);
        int bit_clks = 16 * int'(limit);
        @(negedge pCLK);
        rx = 1'b0;
        repeat (bit_clks) @(negedge pCLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bit_clks) @(negedge pCLK);
        end
        rx = stop_bit;
        for (int i = 0; i < bit_clks; i++) begin
            if (pop_mid) bus.rd_req = (i == 18);
            if (timing_chk && i == 8)  check("rx_empty_before_stop_mid", bus.rx_empty, 1);
            if (timing_chk && i == 24) check("rx_empty_after_stop_mid", bus.rx_empty, 0);
            @(negedge pCLK);
        end
        if (!stop_bit)                  exp_frame_err = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else                            exp_overrun = 1'b1;
        rx = 1'b1;
        repeat (2 * bit_clks) @(negedge pCLK);
    endtask

    task automatic read_one();
        @(negedge pCLK);
        bus.rd_req = 1'b1;
        @(negedge pCLK);
        bus.rd_req = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge pCLK);
        err_clr = 1'b1;
        @(negedge pCLK);
        err_clr = 1'b0;
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
        @(negedge pCLK);
    endtask

    task automatic do_reset();
        @(negedge pCLK);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge pCLK);
        reset = 1'b0;
        model_q.delete();
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
        @(negedge pCLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"},   bus.rd_data,  0);
        check({tag, "_rx_empty"},  bus.rx_empty, 1);
        check({tag, "_rx_full"},   bus.rx_full,  0);
        check({tag, "_frame_err"}, frame_err,    0);
        check({tag, "_overrun"},   overrun,      0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"}, frame_err, exp_frame_err);
        check({tag, "_overrun"},   overrun,   exp_overrun);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] loop_bytes [3];
        logic [7:0] partial;

        reset         = 1'b1;
        rx            = 1'b1;
        rx_en         = 1'b1;
        err_clr       = 1'b0;
        limit         = 16'd2;
        bus.rd_req    = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = '0;
        repeat (4) @(negedge pCLK);
        reset = 1'b0;
        @(negedge pCLK);
        check_reset_outputs("reset");

        // Single frame with stop-sample timing window.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check_flags("a5");
        read_one();

        // Short low glitch must be rejected at the start-bit mid sample.
        @(negedge pCLK);
        rx = 1'b0;
        repeat (8) @(negedge pCLK);
        rx = 1'b1;
        repeat (40) @(negedge pCLK);
        check("glitch_rx_empty", bus.rx_empty, 1);
        check("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_flags("stop0");
        check("stop0_rx_empty", bus.rx_empty, 1);
        clear_errors();
        check_flags("stop0_cleared");

        // Overflow: 0x01..0x05 without reads.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 4) check("full_after_4", bus.rx_full, 1);
        end
        check("full_after_5", bus.rx_full, 1);
        check_flags("ovf");
        for (int i = 0; i < 5; i++) read_one();
        check("ovf_drained_empty", bus.rx_empty, 1);
        clear_errors();
        check_flags("ovf_cleared");

        // Full buffer, pop coinciding with the stop-bit push.
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b1);
        check("coincide_full", bus.rx_full, 1);
        check_flags("coincide");
        for (int i = 0; i < 4; i++) read_one();
        check("coincide_drained", bus.rx_empty, 1);

        // Reset in the middle of data bit 3 with a byte already buffered.
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        partial = 8'hC6;
        @(negedge pCLK);
        rx = 1'b0;
        repeat (32) @(negedge pCLK);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            repeat (32) @(negedge pCLK);
        end
        rx = partial[3];
        repeat (16) @(negedge pCLK);
        do_reset();
        check_reset_outputs("midreset");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        read_one();
        check_flags("after_reset");

        // rx_en drop abandons the frame but keeps buffer and flags.
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        @(negedge pCLK);
        rx = 1'b0;
        repeat (96) @(negedge pCLK);
        rx_en = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge pCLK);
        rx_en = 1'b1;
        repeat (600) @(negedge pCLK);
        check("rxen_kept_entry", bus.rx_empty, 0);
        check_flags("rxen");
        read_one();
        check("rxen_drained", bus.rx_empty, 1);
        clear_errors();

        // limit=0 generates no ticks, so nothing can be received.
        limit = 16'd0;
        @(negedge pCLK);
        rx = 1'b0;
        repeat (200) @(negedge pCLK);
        rx = 1'b1;
        repeat (400) @(negedge pCLK);
        check("limit0_rx_empty", bus.rx_empty, 1);
        rx_en = 1'b0;
        repeat (2) @(negedge pCLK);
        rx_en = 1'b1;
        limit = 16'd2;

        // Loopback-style bytes at 32 clocks per bit.
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            send_frame(loop_bytes[i], 1'b1, 1'b0, 1'b0);
            read_one();
        end
        check_flags("loopback");

        // Randomized traffic with varying rate and read pressure.
        for (int i = 0; i < 10; i++) begin
            limit = 16'($urandom_range(1, 3));
            b     = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0);
            check("rand_full", bus.rx_full, (model_q.size() == DEPTH) ? 1 : 0);
            for (int r = $urandom_range(0, 2); r > 0; r--) read_one();
        end
        for (int i = 0; i < DEPTH; i++) read_one();
        check("rand_drained", bus.rx_empty, 1);
        check_flags("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
